dir_data_fifo: RTL and testbench



---
 rtl/dir_intf_pkg.sv | 12 +
 rtl/dir_fifo_mem.sv | 25 ++
 rtl/dir_data_fifo.sv | 93 +++++++++
 tb/tb_dir_data_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_intf_pkg.sv
// Shared types and sizing helpers for the dir_intf data path.
package dir_intf_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] dir_data_t;

    function automatic int dir_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dir_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port, no reset.
module dir_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dir_data_fifo.sv
// Elastic valid/ready buffer ahead of the dir_intf consumer port.
// Define DIR_FIFO_BYPASS_EN for zero-latency fall-through when the buffer is empty.
module dir_data_fifo
    import dir_intf_pkg::*;
#(
    parameter int DATA_W = dir_intf_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [dir_cnt_w(DEPTH)-1:0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = dir_cnt_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dir_data_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              init_done;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] rdata;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    // Depends only on registered state, so a same-cycle pop never opens a slot.
    assign in_ready = !full && init_done;
    assign pop      = !empty && out_ready;
    assign count    = count_q;

`ifdef DIR_FIFO_BYPASS_EN
    logic byp;

    assign byp       = empty && in_valid && in_ready;
    // A word handed straight through is never written to storage.
    assign push      = in_valid && in_ready && !(byp && out_ready);
    assign out_valid = !empty || byp;
    assign out_data  = !empty ? rdata : (byp ? in_data : '0);
`else
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
        end else begin
            init_done <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    dir_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dir_data_fifo.sv
// Scoreboard bench for dir_data_fifo: accepted words queue up as expectations, the monitor checks outputs.
module tb_dir_data_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         words_out = 0;
    bit         tb_init = 1'b0;
    bit         rnd_rdy = 1'b0;

    int         sz;
    bit         exp_rdy;
    bit         byp;
    bit         exp_ov;
    logic [7:0] exp_od;

    dir_data_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Readiness is a spec rule: it appears on the first edge after reset is released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_init <= 1'b0;
        else        tb_init <= 1'b1;
    end

    // Monitor and scoreboard: the reference is an ordered queue of accepted words.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_count", {29'd0, count}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
        end else begin
            sz      = exp_q.size();
            exp_rdy = tb_init && (sz < DEPTH);
            byp     = 1'b0;
`ifdef DIR_FIFO_BYPASS_EN
            byp     = (sz == 0) && in_valid && exp_rdy;
`endif
            exp_ov  = (sz != 0) || byp;
            exp_od  = (sz != 0) ? exp_q[0] : (byp ? in_data : 8'h00);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            chk("out_data", {24'd0, out_data}, {24'd0, exp_od});
            chk("count", {29'd0, count}, sz);
            if (sz != 0 && out_ready) begin
                void'(exp_q.pop_front());
                words_out++;
            end
            if (in_valid && exp_rdy) begin
                if (byp && out_ready) words_out++;
                else                  exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic push_word(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (n >= 200) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (count != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        idle(3);
        chk("hold_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("hold_rst_count", {29'd0, count}, 32'd0);
        rst_n = 1'b1;
        #2;
        chk("pre_edge_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_edge_in_ready", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(fill[i]);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);

        base = words_out;
        out_ready = 1'b1;
        idle(4);
        chk("drain_count", {29'd0, count}, 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_words", words_out - base, 32'd4);

        base = words_out;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
            push_word(8'hA0 + 8'(i));
        end
        wait_empty();
        rnd_rdy = 1'b0;
        out_ready = 1'b0;
        chk("wrap_words", words_out - base, 32'd10);

        for (int i = 0; i < 4; i++) push_word(8'h60 + 8'(i));
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("full_pop_count", {29'd0, count}, 32'd3);
        chk("full_pop_reopen", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        wait_empty();
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) push_word(8'h90 + 8'(i));
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = words_out;
        out_ready = 1'b1;
        push_word(8'h5A);
        wait_empty();
        chk("post_rst_words", words_out - base, 32'd1);

        idle(1);
        in_valid  = 1'b1;
        in_data   = 8'hC3;
        out_ready = 1'b1;
        #1;
`ifdef DIR_FIFO_BYPASS_EN
        chk("byp_same_out_valid", {31'd0, out_valid}, 32'd1);
        chk("byp_same_out_data", {24'd0, out_data}, 32'hC3);
        chk("byp_same_count", {29'd0, count}, 32'd0);
`else
        chk("nobyp_same_out_valid", {31'd0, out_valid}, 32'd0);
        chk("nobyp_same_out_data", {24'd0, out_data}, 32'd0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef DIR_FIFO_BYPASS_EN
        chk("byp_next_count", {29'd0, count}, 32'd0);
        chk("byp_next_out_valid", {31'd0, out_valid}, 32'd0);
`else
        chk("nobyp_next_out_valid", {31'd0, out_valid}, 32'd1);
        chk("nobyp_next_out_data", {24'd0, out_data}, 32'hC3);
        chk("nobyp_next_count", {29'd0, count}, 32'd1);
`endif
        wait_empty();
        idle(2);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
